// File: rtl/btn_pkg.sv
// Shared state encoding and sizing helper for the push-button conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } btn_state_t;

  // Bits needed to hold 0..cycles; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM and press/release pulses.
// Defining BTN_AUTOREPEAT_EN adds periodic press re-pulses while the button is held.
module button_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef BTN_AUTOREPEAT_EN
  , parameter int REPEAT_CYCLES = 12500000
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic pressed_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  // State table
  //   IDLE         | released, waiting for the synchronized input to go high
  //   PRESS_WAIT   | input high, counting stable cycles before accepting the press
  //   PRESSED      | press accepted, level output high
  //   RELEASE_WAIT | input low, counting stable cycles before accepting the release

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             sync1_q, sync2_q;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rep_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pressed_i;
      sync2_q <= sync1_q;
    end
  end

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q)              state_d = IDLE;
        else if (cnt_q == CNT_LAST) state_d = PRESSED;
        else                        cnt_d   = cnt_inc;
      end
      PRESSED: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sync2_q)               state_d = PRESSED;
        else if (cnt_q == CNT_LAST) state_d = IDLE;
        else                        cnt_d   = cnt_inc;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = cnt_width(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q, rep_d;

  // Counter only advances while held in PRESSED; RELEASE_WAIT freezes it.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (state_d == IDLE || state_d == PRESS_WAIT) begin
      rep_d = '0;
    end else if (state_q == PRESSED && state_d == PRESSED) begin
      if (rep_q == REP_LAST) begin
        rep_d    = '0;
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + REP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Outputs are registered from the next state so they line up with the state change.
  always_comb begin
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = ((state_q == PRESS_WAIT) && (state_d == PRESSED)) || rep_fire;
    release_d = (state_q == RELEASE_WAIT) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: polarity normalise, then one independent debounce channel per button.
// Defining BTN_AUTOREPEAT_EN enables auto-repeat press pulses in every channel.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACTIVE_LOW_BTN  = 1,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  if (DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("button_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 1");
  end

  logic [N_BTN-1:0] pressed_raw;

  assign pressed_raw = (ACTIVE_LOW_BTN != 0) ? ~btn_raw : btn_raw;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTOREPEAT_EN
      , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .pressed_i(pressed_raw[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: stimulus queues expected pulses, a negedge monitor checks them.
module tb_button_conditioner;

  localparam int D   = 4;
  localparam int LAT = D + 3;
  localparam int REP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] btn_raw = 3'b111;
  logic [2:0] btn_level, btn_press, btn_release;

  button_conditioner #(
    .N_BTN(3), .DEBOUNCE_CYCLES(D), .ACTIVE_LOW_BTN(1), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  typedef struct {
    int         cyc;
    logic [2:0] press;
    logic [2:0] rel;
  } ev_t;

  ev_t        exp_q[$];
  int         checks = 0;
  int         fails = 0;
  logic [2:0] lvl_model = 3'b000;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, act, exp);
    end
  endtask

  task automatic expect_ev(input int cyc, input logic [2:0] p, input logic [2:0] r);
    ev_t e;
    e.cyc = cyc; e.press = p; e.rel = r;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    ev_t e;
    if (!reset) lvl_model = 3'b000;
    if (exp_q.size() != 0 && exp_q[0].cyc == edge_n) begin
      e = exp_q.pop_front();
      check("press_pulse", btn_press, e.press);
      check("release_pulse", btn_release, e.rel);
      lvl_model = (lvl_model | e.press) & ~e.rel;
    end else begin
      check("no_pulse", btn_press | btn_release, 3'b000);
      if (exp_q.size() != 0 && exp_q[0].cyc < edge_n) begin
        e = exp_q.pop_front();
        checks++;
        fails++;
        $display("FAIL missed_event: expected at edge %0d, now edge %0d", e.cyc, edge_n);
      end
    end
    check("level", btn_level, lvl_model);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press the buttons in mask for hold cycles, queue press, repeats and release.
  task automatic press_hold(input logic [2:0] mask, input int hold);
    int n;
    @(negedge clk);
    n = edge_n;
    btn_raw = btn_raw & ~mask;
    expect_ev(n + LAT, mask, 3'b000);
`ifdef BTN_AUTOREPEAT_EN
    for (int t = n + LAT + REP; t <= n + hold + 2; t += REP) expect_ev(t, mask, 3'b000);
`endif
    wait_cyc(hold);
    btn_raw = btn_raw | mask;
    expect_ev(n + hold + LAT, 3'b000, mask);
    wait_cyc(10);
  endtask

  // A low pulse of len cycles that must never be accepted.
  task automatic glitch(input logic [2:0] mask, input int len);
    @(negedge clk);
    btn_raw = btn_raw & ~mask;
    wait_cyc(len);
    btn_raw = btn_raw | mask;
    wait_cyc(10);
  endtask

  initial begin
    int m, r;
    wait_cyc(3);
    check("reset_level", btn_level, 3'b000);
    check("reset_press", btn_press, 3'b000);
    check("reset_release", btn_release, 3'b000);
    @(negedge clk); #2 reset = 1'b1;
    wait_cyc(5);

    // Clean press on channel 0
    press_hold(3'b001, 20);
    // Shortest accepted press and longest rejected ones
    press_hold(3'b001, 5);
    glitch(3'b100, 4);
    glitch(3'b100, 3);

    // Bounce on channel 1, then settle low
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); btn_raw[1] = 1'b0;
      wait_cyc(1);
      @(negedge clk); btn_raw[1] = 1'b1;
      wait_cyc(1);
    end
    press_hold(3'b010, 10);

    // Simultaneous presses on channels 0 and 2
    press_hold(3'b101, 8);

    // Long hold (repeats when auto-repeat is built in)
    press_hold(3'b001, 40);

    // Reset in the middle of channel 0 debounce while channel 1 is held
    @(negedge clk);
    btn_raw[1] = 1'b0;
    expect_ev(edge_n + LAT, 3'b010, 3'b000);
    wait_cyc(7);
    @(negedge clk);
    m = edge_n;
    btn_raw[0] = 1'b0;
    while (edge_n < m + 6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_rst_level", btn_level, 3'b000);
    check("async_rst_press", btn_press, 3'b000);
    check("async_rst_release", btn_release, 3'b000);
    wait_cyc(3);
    @(negedge clk);
    r = edge_n;
    #2 reset = 1'b1;
    expect_ev(r + LAT, 3'b011, 3'b000);
    wait_cyc(8);
    @(negedge clk);
    btn_raw = 3'b111;
    expect_ev(edge_n + LAT, 3'b000, 3'b011);
    wait_cyc(12);

    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events never seen", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

endmodule
